tx_ltssm: RTL and testbench

Transmit-side LTSSM ordered-set engine, the counterpart to the receive-side LTSSM that counts incoming TS1/TS2 sets. It builds, per lane, the 16-symbol ordered set that the current substate requires (TS1, TS2 or idle data), presents it to the framing/PIPE path over a valid/ready handshake, and counts the sets sent. It pulses `txFinish` once the substate's transmit obligations are met, taking into account the receive side's `finish`. It sits beside the receive LTSSM under the LTSSM controller, which supplies `substate` and the negotiated fields.

---
 rtl/tx_ltssm.sv | 161 ++++++++++++++++
 tb/tb_tx_ltssm.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_ltssm.sv
// tx_ltssm: transmit-side LTSSM ordered-set engine building per-lane TS1/TS2/idle sets.
// Optional SKP insertion is compiled in when TX_SKP_INSERT_EN is defined.
module tx_ltssm #(
    parameter int         DEVICETYPE        = 0,
    parameter logic [7:0] NFTS              = 8'hFF,
    parameter int         POLL_ACTIVE_COUNT = 1024,
    parameter int         POST_COUNT        = 16,
    parameter int         SKP_INTERVAL      = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [3:0]    substate,
    input  logic [7:0]    linkNumber,
    input  logic [7:0]    rateId,
    input  logic          upConfigureCapability,
    input  logic [4:0]    numberOfDetectedLanes,
    input  logic          rxFinish,
    input  logic          osReady,
    output logic [2047:0] orderedSets,
    output logic          osValid,
    output logic [1:0]    osType,
    output logic          txFinish,
    output logic          busy
);

`ifdef TX_SKP_INSERT_EN
    localparam bit SKP_EN = 1'b1;
`else
    localparam bit SKP_EN = 1'b0;
`endif
    localparam int         SKW = $clog2(SKP_INTERVAL + 1);
    localparam logic [7:0] PAD = 8'hF7;

    typedef enum logic [1:0] {IDLE, SEND, POST, DONE} state_t;

    state_t          state, state_nx;
    logic [3:0]      sub_q, sel_sub;
    logic [10:0]     count, count_inc, min_count;
    logic            rx_seen, cur_skp;
    logic [SKW-1:0]  skp_cnt, skp_inc;
    logic            active, hs, hs_ts, abort, start_ok, skp_hit, post_sub;
    logic [2047:0]   os_build;
    logic [1:0]      type_build;
    logic [127:0]    lane_os;
    logic [7:0]      link_sym, lane_sym, sym4;
    logic            ts2, idle_data, lane_pad;

    assign active    = (state == SEND) || (state == POST);
    assign hs        = active && osReady;
    assign hs_ts     = hs && !cur_skp;
    assign abort     = active && (substate != sub_q);
    assign start_ok  = (state == IDLE) && start && (substate >= 4'd2) && (substate <= 4'd9);
    assign count_inc = (hs_ts && count != 11'h7FF) ? count + 11'd1 : count;
    assign skp_inc   = hs_ts ? skp_cnt + 1'b1 : skp_cnt;
    assign skp_hit   = SKP_EN && hs_ts && (skp_inc == SKW'(SKP_INTERVAL));
    assign min_count = (sub_q == 4'd2) ? 11'(POLL_ACTIVE_COUNT) : 11'd1;
    assign post_sub  = (sub_q == 4'd3) || (sub_q == 4'd8) || (sub_q == 4'd9);
    assign sel_sub   = (state == IDLE) ? substate : sub_q;

    assign osValid  = active;
    assign txFinish = (state == DONE);
    assign busy     = (state != IDLE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start_ok) state_nx = SEND;
            SEND: begin
                if (abort)
                    state_nx = IDLE;
                else if (count_inc >= min_count && (rx_seen || rxFinish))
                    state_nx = post_sub ? POST : DONE;
            end
            POST: begin
                if (abort)
                    state_nx = IDLE;
                else if (count_inc >= 11'(POST_COUNT))
                    state_nx = DONE;
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Content of the next set to present; used on start and after each handshake.
    always_comb begin
        os_build  = '0;
        lane_os   = '0;
        ts2       = (sel_sub == 4'd3) || (sel_sub == 4'd8);
        idle_data = (sel_sub == 4'd9);
        link_sym  = PAD;
        lane_pad  = 1'b1;
        case (sel_sub)
            4'd4: link_sym = (DEVICETYPE == 0) ? linkNumber : PAD;
            4'd5: link_sym = linkNumber;
            4'd6, 4'd7, 4'd8: begin
                link_sym = linkNumber;
                lane_pad = 1'b0;
            end
            default: link_sym = PAD;
        endcase
        sym4 = rateId;
        if (ts2) sym4[6] = upConfigureCapability;
        for (int i = 0; i < 16; i++) begin
            lane_os  = '0;
            lane_sym = lane_pad ? PAD : 8'(i);
            if (skp_hit) begin
                lane_os[31:0] = {8'h1C, 8'h1C, 8'h1C, 8'hBC};
            end else if (!idle_data) begin
                lane_os[47:0] = {8'h00, sym4, NFTS, lane_sym, link_sym, 8'hBC};
                for (int k = 6; k < 16; k++)
                    lane_os[k*8 +: 8] = ts2 ? 8'h45 : 8'h4A;
            end
            if (5'(i) < numberOfDetectedLanes)
                os_build[i*128 +: 128] = lane_os;
        end
        if (skp_hit)        type_build = 2'd3;
        else if (idle_data) type_build = 2'd2;
        else if (ts2)       type_build = 2'd1;
        else                type_build = 2'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            sub_q       <= '0;
            count       <= '0;
            rx_seen     <= 1'b0;
            skp_cnt     <= '0;
            cur_skp     <= 1'b0;
            orderedSets <= '0;
            osType      <= 2'd0;
        end else begin
            state <= state_nx;
            if (start_ok) begin
                sub_q       <= substate;
                count       <= '0;
                rx_seen     <= 1'b0;
                skp_cnt     <= '0;
                cur_skp     <= 1'b0;
                orderedSets <= os_build;
                osType      <= type_build;
            end else if (active) begin
                if (rxFinish) rx_seen <= 1'b1;
                count   <= (state == SEND && state_nx == POST) ? 11'd0 : count_inc;
                skp_cnt <= skp_hit ? '0 : skp_inc;
                if (state_nx != SEND && state_nx != POST) begin
                    orderedSets <= '0;
                    osType      <= 2'd0;
                    cur_skp     <= 1'b0;
                end else if (hs) begin
                    orderedSets <= os_build;
                    osType      <= type_build;
                    cur_skp     <= skp_hit;
                end
            end
        end
    end

endmodule

// File: tb/tb_tx_ltssm.sv
// Bench for tx_ltssm: table-driven substate runs, randomized back-pressure runs and corner sequences.
module tb_tx_ltssm;
    localparam int POLL = 8;
    localparam int POST = 16;
    localparam int SKPI = 4;
`ifdef TX_SKP_INSERT_EN
    localparam bit SKP_ON = 1'b1;
`else
    localparam bit SKP_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, start, upConfigureCapability, rxFinish, osReady;
    logic [3:0]    substate;
    logic [7:0]    linkNumber, rateId;
    logic [4:0]    numberOfDetectedLanes;
    logic [2047:0] os0, os1;
    logic          osValid0, osValid1, txFinish0, txFinish1, busy0, busy1;
    logic [1:0]    osType0, osType1;
    int            checks = 0;
    int            failures = 0;

    always #5 clk = ~clk;

    tx_ltssm #(.DEVICETYPE(0), .NFTS(8'hFF), .POLL_ACTIVE_COUNT(POLL), .POST_COUNT(POST),
               .SKP_INTERVAL(SKPI)) u_dut0 (
        .clk(clk), .reset(reset), .start(start), .substate(substate), .linkNumber(linkNumber),
        .rateId(rateId), .upConfigureCapability(upConfigureCapability),
        .numberOfDetectedLanes(numberOfDetectedLanes), .rxFinish(rxFinish), .osReady(osReady),
        .orderedSets(os0), .osValid(osValid0), .osType(osType0), .txFinish(txFinish0), .busy(busy0));

    tx_ltssm #(.DEVICETYPE(1), .NFTS(8'hFF), .POLL_ACTIVE_COUNT(POLL), .POST_COUNT(POST),
               .SKP_INTERVAL(SKPI)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .substate(substate), .linkNumber(linkNumber),
        .rateId(rateId), .upConfigureCapability(upConfigureCapability),
        .numberOfDetectedLanes(numberOfDetectedLanes), .rxFinish(rxFinish), .osReady(osReady),
        .orderedSets(os1), .osValid(osValid1), .osType(osType1), .txFinish(txFinish1), .busy(busy1));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_os(input string name, input logic [2047:0] act, input logic [2047:0] exp);
        bit shown;
        checks++;
        shown = 1'b0;
        if (act !== exp) begin
            failures++;
            for (int i = 0; i < 16; i++)
                if (!shown && act[i*128 +: 128] !== exp[i*128 +: 128]) begin
                    $display("FAIL %s lane %0d: got %h expected %h", name, i,
                             act[i*128 +: 128], exp[i*128 +: 128]);
                    shown = 1'b1;
                end
        end
    endtask

    // Expected set contents straight from the symbol tables of each substate.
    function automatic logic [2047:0] exp_set(input int dev, input int sub, input bit skp);
        logic [2047:0] r;
        logic [7:0]    s [16];
        bit            ts2;
        r   = '0;
        ts2 = (sub == 3) || (sub == 8);
        for (int i = 0; i < int'(numberOfDetectedLanes); i++) begin
            for (int k = 0; k < 16; k++) s[k] = 8'h00;
            if (skp) begin
                s[0] = 8'hBC; s[1] = 8'h1C; s[2] = 8'h1C; s[3] = 8'h1C;
            end else if (sub != 9) begin
                s[0] = 8'hBC;
                s[1] = (sub <= 3 || (sub == 4 && dev == 1)) ? 8'hF7 : linkNumber;
                s[2] = (sub <= 5) ? 8'hF7 : 8'(i);
                s[3] = 8'hFF;
                s[4] = rateId;
                if (ts2) s[4][6] = upConfigureCapability;
                for (int k = 6; k < 16; k++) s[k] = ts2 ? 8'h45 : 8'h4A;
            end
            for (int k = 0; k < 16; k++) r[i*128 + k*8 +: 8] = s[k];
        end
        return r;
    endfunction

    function automatic logic [1:0] exp_type(input int sub, input bit skp);
        if (skp) return 2'd3;
        if (sub == 9) return 2'd2;
        if (sub == 3 || sub == 8) return 2'd1;
        return 2'd0;
    endfunction

    // mode 0: always ready, 1: random ready, 2: ready low on loop cycles 3..5.
    task automatic run_case(input int sub, input int rx_at, input int mode, output int n_ts,
                            output logic [2047:0] f0, output logic [2047:0] f1);
        int total, ts_since;
        bit rx_done, exp_skp, nxt_skp, ended;
        total = ((sub == 2) ? ((rx_at > POLL) ? rx_at : POLL) : rx_at)
              + ((sub == 3 || sub == 8 || sub == 9) ? POST : 0);
        substate = 4'(sub);
        rxFinish = 1'b0;
        osReady  = 1'b0;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy0, 1);
        f0 = os0;
        f1 = os1;
        n_ts = 0; ts_since = 0; rx_done = 1'b0; exp_skp = 1'b0; ended = 1'b0;
        for (int cyc = 0; cyc < 400 && !ended; cyc++) begin
            case (mode)
                0:       osReady = 1'b1;
                1:       osReady = ($urandom_range(0, 3) != 0);
                default: osReady = !(cyc >= 3 && cyc <= 5);
            endcase
            rxFinish = !rx_done && (n_ts + ((osReady && !exp_skp) ? 1 : 0) == rx_at);
            if (rxFinish) rx_done = 1'b1;
            chk("osValid0", osValid0, 1);
            chk("osValid1", osValid1, 1);
            chk("osType0", osType0, exp_type(sub, exp_skp));
            chk_os("os0", os0, exp_set(0, sub, exp_skp));
            chk_os("os1", os1, exp_set(1, sub, exp_skp));
            nxt_skp = exp_skp;
            if (osReady) begin
                if (exp_skp) nxt_skp = 1'b0;
                else begin
                    n_ts++;
                    ts_since++;
                    if (SKP_ON && ts_since == SKPI) begin
                        nxt_skp  = 1'b1;
                        ts_since = 0;
                    end
                end
            end
            @(posedge clk); #1;
            rxFinish = 1'b0;
            exp_skp  = nxt_skp;
            if (rx_done && n_ts >= total) ended = 1'b1;
        end
        osReady = 1'b0;
        if (!ended) begin
            checks++;
            failures++;
            $display("FAIL run_case_timeout sub %0d: got %0d sets expected %0d", sub, n_ts, total);
        end else begin
            chk("done_txFinish0", txFinish0, 1);
            chk("done_txFinish1", txFinish1, 1);
            chk("done_osValid0", osValid0, 0);
            chk("done_busy0", busy0, 1);
            @(posedge clk); #1;
            chk("after_done_txFinish0", txFinish0, 0);
            chk("after_done_busy0", busy0, 0);
        end
    endtask

    typedef struct {
        int         sub;
        int         lanes;
        logic [7:0] link;
        logic [7:0] rate;
        logic       up;
        int         rx_at;
        int         mode;
        int         sent;
        int         lane;
        int         sym;
        logic [7:0] e0;
        logic [7:0] e1;
    } vec_t;

    vec_t          vt [10];
    int            n, sub_r, rx_r;
    logic [2047:0] f0, f1;

    initial begin
        vt[0] = '{2, 4, 8'h05, 8'h02, 1'b0, 3, 0, 8, 0, 6, 8'h4A, 8'h4A};
        vt[1] = '{2, 4, 8'h05, 8'h02, 1'b0, 10, 0, 10, 0, 1, 8'hF7, 8'hF7};
        vt[2] = '{8, 4, 8'h05, 8'h02, 1'b1, 2, 2, 18, 3, 2, 8'h03, 8'h03};
        vt[3] = '{8, 4, 8'h05, 8'h02, 1'b1, 2, 0, 18, 4, 0, 8'h00, 8'h00};
        vt[4] = '{4, 2, 8'h2A, 8'h02, 1'b0, 1, 0, 1, 0, 1, 8'h2A, 8'hF7};
        vt[5] = '{3, 1, 8'h2A, 8'h02, 1'b1, 1, 0, 17, 0, 4, 8'h42, 8'h42};
        vt[6] = '{9, 3, 8'h2A, 8'h02, 1'b1, 5, 0, 21, 0, 0, 8'h00, 8'h00};
        vt[7] = '{6, 16, 8'h11, 8'h03, 1'b0, 2, 0, 2, 15, 2, 8'h0F, 8'h0F};
        vt[8] = '{5, 2, 8'h2A, 8'h02, 1'b0, 1, 0, 1, 1, 2, 8'hF7, 8'hF7};
        vt[9] = '{7, 1, 8'h33, 8'h02, 1'b0, 3, 0, 3, 0, 3, 8'hFF, 8'hFF};

        reset = 1'b1; start = 1'b0; substate = 4'd0; linkNumber = 8'h05; rateId = 8'h02;
        upConfigureCapability = 1'b0; numberOfDetectedLanes = 5'd4; rxFinish = 1'b0; osReady = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_osValid", osValid0, 0);
        chk("rst_osType", osType0, 0);
        chk("rst_txFinish", txFinish0, 0);
        chk("rst_busy", busy0, 0);
        chk_os("rst_os", os0, '0);
        reset = 1'b0;

        // Non-transmitting substates must not start the engine.
        substate = 4'd10; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("ignore_sub10_busy", busy0, 0);
        substate = 4'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("ignore_sub1_valid", osValid0, 0);

        for (int v = 0; v < 10; v++) begin
            numberOfDetectedLanes = 5'(vt[v].lanes);
            linkNumber = vt[v].link;
            rateId = vt[v].rate;
            upConfigureCapability = vt[v].up;
            run_case(vt[v].sub, vt[v].rx_at, vt[v].mode, n, f0, f1);
            chk("tbl_sent", n, vt[v].sent);
            chk("tbl_sym_dut0", f0[vt[v].lane*128 + vt[v].sym*8 +: 8], vt[v].e0);
            chk("tbl_sym_dut1", f1[vt[v].lane*128 + vt[v].sym*8 +: 8], vt[v].e1);
        end

        // Abort: substate changes mid-SEND.
        numberOfDetectedLanes = 5'd4; linkNumber = 8'h05;
        substate = 4'd8; osReady = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("abort_pre_busy", busy0, 1);
        substate = 4'd6;
        @(posedge clk); #1;
        chk("abort_osValid", osValid0, 0);
        chk("abort_busy", busy0, 0);
        chk("abort_txFinish", txFinish0, 0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("abort_no_txFinish", txFinish0, 0);
        end
        osReady = 1'b0;

        // Reset while in POST, then a fresh start counts from zero.
        substate = 4'd8; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; rxFinish = 1'b1; osReady = 1'b1;
        @(posedge clk); #1;
        rxFinish = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("post_busy", busy0, 1);
        chk("post_osValid", osValid0, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; osReady = 1'b0;
        chk("rstpost_osValid", osValid0, 0);
        chk("rstpost_busy", busy0, 0);
        chk("rstpost_osType", osType0, 0);
        chk("rstpost_txFinish", txFinish0, 0);
        chk_os("rstpost_os", os0, '0);
        run_case(8, 2, 0, n, f0, f1);
        chk("rstpost_restart_sent", n, 18);

        // Randomized runs with random back-pressure.
        for (int r = 0; r < 8; r++) begin
            sub_r = $urandom_range(2, 9);
            rx_r  = $urandom_range(1, 12);
            numberOfDetectedLanes = 5'($urandom_range(1, 16));
            linkNumber = 8'($urandom_range(0, 255));
            rateId = 8'($urandom_range(0, 255));
            upConfigureCapability = 1'($urandom_range(0, 1));
            run_case(sub_r, rx_r, 1, n, f0, f1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
